// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the single-clock FIFO.
// Optional error flags are enabled with FIFO_ERR_FLAGS_EN.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 2;

  // Occupancy counter width: must be able to hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and full/empty bookkeeping for sync_2entry_fifo.
// Sticky overflow/underflow flags exist only with FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             full,
  output logic             empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_acc, pop_acc;
`ifdef FIFO_ERR_FLAGS_EN
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
`endif

  // Next-state: accept requests on registered flags, advance pointers.
  always_comb begin
    push_acc = push && !full_q;
    pop_acc  = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
`ifdef FIFO_ERR_FLAGS_EN
    ovf_d = ovf_q | (push && full_q);
    unf_d = unf_q | (pop && empty_q);
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
`ifdef FIFO_ERR_FLAGS_EN
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
`ifdef FIFO_ERR_FLAGS_EN
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`endif
    end
  end

  assign wr_en  = push_acc;
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign count  = count_q;
`ifdef FIFO_ERR_FLAGS_EN
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: rtl/sync_2entry_fifo.sv
// Single-clock first-word-fall-through FIFO: storage, write decode, read mux.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_2entry_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  sync_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wr_en     (wr_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .full      (full),
    .empty     (empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .count     (count)
  );

  // Write decode: only the slot under wr_ptr takes the new word.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr] = wdata;
  end

  // Storage array, cleared on reset so rdata reads zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr];

endmodule

// File: tb/tb_sync_2entry_fifo.sv
// Self-checking bench for sync_2entry_fifo: queue model plus directed pins.
// Compile with FIFO_ERR_FLAGS_EN to also check the sticky error flags.
module tb_sync_2entry_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [DW-1:0] wdata;
  logic          full;
  logic          pop;
  logic [DW-1:0] rdata;
  logic          empty;
  logic [CW-1:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] q[$];
  bit ov_m = 0;
  bit un_m = 0;

  always #5 clk = ~clk;

  sync_2entry_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wdata     (wdata),
    .full      (full),
    .pop       (pop),
    .rdata     (rdata),
    .empty     (empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .count     (count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model comparison, run once per cycle after the edge settles.
  task automatic compare();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    if (q.size() > 0) chk("rdata", 32'(rdata), 32'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(ov_m));
    chk("underflow", 32'(underflow), 32'(un_m));
`endif
  endtask

  task automatic step(input logic r, input logic p,
                      input logic [DW-1:0] d, input logic o);
    int n;
    reset = r; push = p; wdata = d; pop = o;
    @(posedge clk);
    n = q.size();
    if (r) begin
      q.delete();
      ov_m = 0;
      un_m = 0;
    end else begin
      if (p && n == DEPTH) ov_m = 1;
      if (o && n == 0) un_m = 1;
      if (o && n > 0) void'(q.pop_front());
      if (p && n < DEPTH) q.push_back(d);
    end
    #1;
    compare();
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; wdata = '0; pop = 1'b0;

    // Reset held two cycles with push asserted.
    step(1, 1, 8'h55, 0);
    step(1, 1, 8'h55, 0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);

    // Fill.
    step(0, 1, 8'hA1, 0);
    chk("fill1_count", 32'(count), 32'd1);
    chk("fill1_empty", 32'(empty), 32'd0);
    chk("fill1_rdata", 32'(rdata), 32'hA1);
    step(0, 1, 8'hB2, 0);
    chk("fill2_count", 32'(count), 32'd2);
    chk("fill2_full", 32'(full), 32'd1);
    chk("fill2_rdata", 32'(rdata), 32'hA1);

    // Push while full is dropped.
    step(0, 1, 8'hC3, 0);
    chk("ovf_count", 32'(count), 32'd2);
    chk("ovf_rdata", 32'(rdata), 32'hA1);
    step(0, 0, 8'h00, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_sticky", 32'(overflow), 32'd1);
`endif

    // Drain with idle gaps, then an extra pop.
    step(0, 0, 8'h00, 1);
    chk("drain1_rdata", 32'(rdata), 32'hB2);
    chk("drain1_count", 32'(count), 32'd1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    chk("drain2_count", 32'(count), 32'd0);
    chk("drain2_empty", 32'(empty), 32'd1);
    step(0, 0, 8'h00, 1);
    chk("unf_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_flag", 32'(underflow), 32'd1);
`endif

    // Simultaneous push and pop cases.
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 1);
    chk("sim1_count", 32'(count), 32'd1);
    chk("sim1_rdata", 32'(rdata), 32'h22);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h33, 1);
    chk("sim0_count", 32'(count), 32'd1);
    chk("sim0_rdata", 32'(rdata), 32'h33);
    step(0, 1, 8'h44, 0);
    chk("simf_pre", 32'(full), 32'd1);
    step(0, 1, 8'h55, 1);
    chk("simf_count", 32'(count), 32'd1);
    chk("simf_rdata", 32'(rdata), 32'h44);
    step(0, 0, 8'h00, 1);

    // Wrap: six push/pop pairs.
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 8'(i), 0);
      chk("wrap_rdata", 32'(rdata), 32'(i));
      chk("wrap_count", 32'(count), 32'd1);
      step(0, 0, 8'h00, 1);
      chk("wrap_empty", 32'(empty), 32'd1);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) < 2, $urandom_range(1), 8'($urandom),
           $urandom_range(1));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
